// File: rtl/barrel_shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shift_pkg
//  Description : Shared types and helpers for the pipelined barrel shifter:
//                direction and mode encodings, power-of-two check.
//  Revision    : 1.0 - initial release
// ============================================================================
package barrel_shift_pkg;

    // Direction applies to every mode, not only rotation
    typedef enum logic {
        ROTATE_LEFT  = 1'b0,
        ROTATE_RIGHT = 1'b1
    } dir_t;

    // Encoding 2'b11 is reserved and decodes as a logical shift
    typedef enum logic [1:0] {
        MODE_ROTATE  = 2'd0,
        MODE_LOGICAL = 2'd1,
        MODE_ARITH   = 2'd2
    } shift_mode_t;

    // True when value is a non-zero power of two
    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_shift_stage.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shift_stage
//  Description : One elastic pipeline stage of the barrel shifter. Shifts or
//                rotates the incoming beat by 2^K when amt[K] is set, and
//                registers the result with the beat's control fields.
//                Optional flags (zero / spilled bits) are built when
//                BARREL_SHIFT_FLAGS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int K      = 0,
    localparam int NSTAGE = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [WIDTH-1:0]  i_data,
    input  logic [NSTAGE-1:0] i_amt,
    input  logic              i_dir,
    input  logic [1:0]        i_mode,
`ifdef BARREL_SHIFT_FLAGS_EN
    input  logic              i_spill,
    output logic              o_spill,
    output logic              o_zero,
`endif
    input  logic              i_ready,
    output logic              o_valid,
    output logic [WIDTH-1:0]  o_data,
    output logic [NSTAGE-1:0] o_amt,
    output logic              o_dir,
    output logic [1:0]        o_mode
);

    localparam int c_shift = 2 ** K;

    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic [NSTAGE-1:0] r_amt;
    logic              r_dir;
    logic [1:0]        r_mode;

    logic              w_load;
    logic              w_is_rot;
    logic              w_fill;
    logic [WIDTH-1:0]  w_rotl;
    logic [WIDTH-1:0]  w_rotr;
    logic [WIDTH-1:0]  w_shl;
    logic [WIDTH-1:0]  w_shr;
    logic [WIDTH-1:0]  w_next;

    // Stage takes a new beat when empty or when its current beat moves on
    assign w_load = !r_valid || i_ready;

    // Shift network for this stage; right shifts fill with the sign only in arith mode
    always_comb begin
        w_is_rot = (i_mode == MODE_ROTATE);
        w_fill   = (i_mode == MODE_ARITH) && i_data[WIDTH-1];
        w_rotl   = {i_data[WIDTH-c_shift-1:0], i_data[WIDTH-1:WIDTH-c_shift]};
        w_rotr   = {i_data[c_shift-1:0], i_data[WIDTH-1:c_shift]};
        w_shl    = {i_data[WIDTH-c_shift-1:0], {c_shift{1'b0}}};
        w_shr    = {{c_shift{w_fill}}, i_data[WIDTH-1:c_shift]};
        w_next   = i_data;
        if (i_amt[K]) begin
            if (i_dir == ROTATE_RIGHT) begin
                w_next = w_is_rot ? w_rotr : w_shr;
            end else begin
                w_next = w_is_rot ? w_rotl : w_shl;
            end
        end
    end

    // Stage register; data fields only update when a real beat arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
            r_dir   <= 1'b0;
            r_mode  <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_next;
                r_amt  <= i_amt;
                r_dir  <= i_dir;
                r_mode <= i_mode;
            end
        end
    end

`ifdef BARREL_SHIFT_FLAGS_EN
    logic r_spill;
    logic r_zero;
    logic w_spill_next;

    // Accumulate any bit pushed off the end by a non-rotating shift
    always_comb begin
        w_spill_next = i_spill;
        if (i_amt[K] && !w_is_rot) begin
            if (i_dir == ROTATE_RIGHT) begin
                w_spill_next = i_spill | (|i_data[c_shift-1:0]);
            end else begin
                w_spill_next = i_spill | (|i_data[WIDTH-1:WIDTH-c_shift]);
            end
        end
    end

    // Flag registers travel in lock-step with the data register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spill <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_load && i_valid) begin
            r_spill <= w_spill_next;
            r_zero  <= (w_next == '0);
        end
    end

    assign o_spill = r_spill;
    assign o_zero  = r_zero;
`endif

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_amt   = r_amt;
    assign o_dir   = r_dir;
    assign o_mode  = r_mode;

endmodule
`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shifter_pipe
//  Description : Pipelined barrel shifter (rotate / logical / arithmetic, both
//                directions) with one registered stage per amount bit and a
//                valid/ready handshake on each side. Define
//                BARREL_SHIFT_FLAGS_EN to add out_zero and out_spill.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_shifter_pipe
    import barrel_shift_pkg::*;
#(
    parameter  int WIDTH  = 8,
    localparam int NSTAGE = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [NSTAGE-1:0] in_amt,
    input  logic              in_dir_lr,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef BARREL_SHIFT_FLAGS_EN
    output logic              out_zero,
    output logic              out_spill,
`endif
    output logic [WIDTH-1:0]  out_data
);

    if (WIDTH < 2 || !is_pow2(WIDTH)) begin : g_width_check
        $error("barrel_shifter_pipe: WIDTH must be a power of two >= 2");
    end

    // Index 0 is the input port side; index k+1 is the output of stage k
    logic [NSTAGE:0]              w_valid;
    logic [NSTAGE:0]              w_rdy;
    logic [NSTAGE:0]              w_dir;
    logic [NSTAGE:0][WIDTH-1:0]   w_data;
    logic [NSTAGE:0][NSTAGE-1:0]  w_amt;
    logic [NSTAGE:0][1:0]         w_mode;
    logic                         w_tail_full;
    logic                         w_unused_ctrl;

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_amt[0]   = in_amt;
    assign w_dir[0]   = in_dir_lr;
    assign w_mode[0]  = in_mode;

    // A stage may load when out_ready is high or some stage from it to the
    // end is empty; written flat so readiness never loops through itself
    always_comb begin
        w_tail_full    = 1'b1;
        w_rdy          = '0;
        w_rdy[NSTAGE]  = out_ready;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            w_tail_full = w_tail_full & w_valid[k+1];
            w_rdy[k]    = out_ready | ~w_tail_full;
        end
    end

`ifdef BARREL_SHIFT_FLAGS_EN
    logic [NSTAGE:0] w_spill;
    logic [NSTAGE:1] w_zero;
    logic            w_unused_zero;

    assign w_spill[0]    = 1'b0;
    assign out_spill     = w_spill[NSTAGE];
    assign out_zero      = w_zero[NSTAGE];
    assign w_unused_zero = ^w_zero;
`endif

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk     (clk),
            .rst     (reset),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .i_amt   (w_amt[k]),
            .i_dir   (w_dir[k]),
            .i_mode  (w_mode[k]),
`ifdef BARREL_SHIFT_FLAGS_EN
            .i_spill (w_spill[k]),
            .o_spill (w_spill[k+1]),
            .o_zero  (w_zero[k+1]),
`endif
            .i_ready (w_rdy[k+1]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1]),
            .o_amt   (w_amt[k+1]),
            .o_dir   (w_dir[k+1]),
            .o_mode  (w_mode[k+1])
        );
    end

    // Control fields leaving the last stage have no consumer
    assign w_unused_ctrl = ^{w_amt[NSTAGE], w_dir[NSTAGE], w_mode[NSTAGE]};

    assign in_ready  = w_rdy[0];
    assign out_valid = w_valid[NSTAGE];
    assign out_data  = w_data[NSTAGE];

endmodule
`default_nettype wire
